// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the multi-read-port register bank.
//   clr_state_e  : bulk-clear sequencer state (IDLE, CLEAR)
//   calc_be_w    : number of byte enables for a given data width
//   calc_addr_w  : address width for a given entry count
package reg_bank_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int calc_be_w(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// reg_bank_clear_fsm: sequences the bulk clear, zeroing one entry per cycle.
//   clk, rst_n : clock and synchronous active-low reset
//   clr_req    : start request, honoured only in IDLE
//   busy       : high for the DEPTH cycles of a clear
//   clr_we     : zero the entry at clr_addr on the next edge
//   clr_addr   : entry being zeroed this cycle
//   state      : current sequencer state (debug visibility)
module reg_bank_clear_fsm
  import reg_bank_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_e        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A request seen while already clearing is ignored: the sweep neither
  // restarts nor extends.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign state    = state_q;

endmodule

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: register bank with one byte-maskable write port and NUM_RD
// registered read ports with write-to-read bypass, plus a bulk-clear engine.
//   clk, rst_n        : clock and synchronous active-low reset
//   wr_en/addr/be/data: write port; out-of-range addresses are dropped
//   rd_en/rd_addr     : per-port read request, addresses packed per port
//   rd_data/valid/err : per-port registered read response
//   clr_req           : start a bulk clear
//   busy              : clear in progress, reads and writes are dropped
//
// Read handshake: there is no backpressure. A read on port p is accepted on
// any edge where rd_en[p]=1 and busy=0; exactly one cycle later rd_valid[p]
// is high for one cycle with rd_data[p] (and rd_err[p] if the address was out
// of range). rd_data[p] holds its value between accepted reads.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int NUM_RD     = 2,
  localparam int ADDR_W    = calc_addr_w(DEPTH),
  localparam int BE_W      = calc_be_w(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [BE_W-1:0]              wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_err,
  input  logic                         clr_req,
  output logic                         busy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_e        clr_state;

  reg_bank_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (clr_state)
  );

  // busy is defined as "sequencer is in CLEAR"; keep the two views aligned.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (busy == (clr_state == CLEAR));
    end
  end

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({{(32-ADDR_W){1'b0}}, a} < $unsigned(DEPTH));
  endfunction

  logic                  wr_ok;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_ok  = in_range(wr_addr);
  assign wr_acc = wr_en && !busy && wr_ok;

  // The merged word is both what gets stored and what a same-cycle read of
  // the same address returns.
  always_comb begin
    wr_old    = wr_ok ? mem[wr_addr] : '0;
    wr_merged = wr_old;
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        wr_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // The clear is placed after the write so it wins should both ever target
  // one entry on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_addr] <= wr_merged;
      end
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0]     addr;
    logic                  acc;
    logic                  ok;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  err_q;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];
    assign acc  = rd_en[p] && !busy;
    assign ok   = in_range(addr);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= acc;
        err_q   <= acc && !ok;
        if (acc) begin
          if (!ok) begin
            data_q <= '0;
          end else if (wr_acc && (wr_addr == addr)) begin
            data_q <= wr_merged;
          end else begin
            data_q <= mem[addr];
          end
        end
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
    assign rd_valid[p]                         = valid_q;
    assign rd_err[p]                           = err_q;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: self-checking bench for reg_bank_mp (8x16, two read ports)
// plus a DEPTH=6 single-port instance for out-of-range addressing.
module tb_reg_bank_mp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_err;
  logic        clr_req;
  logic        busy;

  logic        wr_en6;
  logic [2:0]  wr_addr6;
  logic [1:0]  wr_be6;
  logic [15:0] wr_data6;
  logic [0:0]  rd_en6;
  logic [2:0]  rd_addr6;
  logic [15:0] rd_data6;
  logic [0:0]  rd_valid6;
  logic [0:0]  rd_err6;
  logic        busy6;

  reg_bank_mp #(.DATA_WIDTH(16), .DEPTH(8), .NUM_RD(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .clr_req(clr_req), .busy(busy)
  );

  reg_bank_mp #(.DATA_WIDTH(16), .DEPTH(6), .NUM_RD(1)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_be(wr_be6), .wr_data(wr_data6),
    .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6),
    .rd_valid(rd_valid6), .rd_err(rd_err6),
    .clr_req(1'b0), .busy(busy6)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int busy_cycles = 0;

  logic [16:0] exp_q0[$];   // {err, data} expected on read port 0
  logic [16:0] exp_q1[$];   // {err, data} expected on read port 1

  logic [15:0] m_mem [8];
  logic        m_clr = 1'b0;
  int          m_ptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input int p);
    logic        have;
    logic [16:0] e;
    have = 1'b0;
    e    = '0;
    if (p == 0 && exp_q0.size() > 0) begin
      have = 1'b1;
      e    = exp_q0.pop_front();
    end else if (p == 1 && exp_q1.size() > 0) begin
      have = 1'b1;
      e    = exp_q1.pop_front();
    end
    check($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(have));
    if (have && rd_valid[p]) begin
      check($sformatf("rd_data%0d", p), 32'(rd_data[p*16 +: 16]), 32'(e[15:0]));
      check($sformatf("rd_err%0d", p), 32'(rd_err[p]), 32'(e[16]));
    end
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus: drive, predict, clock, update model, compare.
  task automatic step(input logic rst, input logic we, input logic [2:0] wa,
                      input logic [1:0] be, input logic [15:0] wd,
                      input logic [1:0] re, input logic [2:0] ra0,
                      input logic [2:0] ra1, input logic clr);
    logic        wacc;
    logic [15:0] mrg;
    logic [15:0] v;
    logic [2:0]  ra [2];
    rst_n   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    rd_en   = re;
    rd_addr = {ra1, ra0};
    clr_req = clr;
    ra[0]   = ra0;
    ra[1]   = ra1;
    wacc    = rst && we && !m_clr;
    mrg     = {be[1] ? wd[15:8] : m_mem[wa][15:8], be[0] ? wd[7:0] : m_mem[wa][7:0]};
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        if (re[p] && !m_clr) begin
          v = (wacc && wa == ra[p]) ? mrg : m_mem[ra[p]];
          if (p == 0) exp_q0.push_back({1'b0, v});
          else        exp_q1.push_back({1'b0, v});
        end
      end
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_clr = 1'b0;
      m_ptr = 0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (wacc) m_mem[wa] = mrg;
      if (m_clr) begin
        m_mem[m_ptr] = '0;
        if (m_ptr == 7) begin
          m_ptr = 0;
          m_clr = 1'b0;
        end else begin
          m_ptr++;
        end
      end else if (clr) begin
        m_clr = 1'b1;
      end
    end
    #1;
    check("busy", 32'(busy), 32'(m_clr));
    if (busy) busy_cycles++;
    check_port(0);
    check_port(1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] be, input logic [15:0] d);
    step(1'b1, 1'b1, a, be, d, 2'b00, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 2'b11, 3'(a), 3'(7 - a), 1'b0);
    end
  endtask

  task automatic fill(input logic [15:0] d);
    for (int a = 0; a < 8; a++) wr(3'(a), 2'b11, d);
  endtask

  task automatic random_busy_step();
    step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'b11,
         16'($urandom_range(1, 65535)), 2'($urandom_range(0, 3)),
         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
         1'($urandom_range(0, 1)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    wr_en6 = 1'b0; wr_addr6 = '0; wr_be6 = '0; wr_data6 = '0;
    rd_en6 = '0;   rd_addr6 = '0;

    // Reset: all outputs quiet, data zero.
    step(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    read_all();

    // Partial write merges with the same-cycle read.
    wr(3'd3, 2'b11, 16'hABCD);
    step(1'b1, 1'b1, 3'd3, 2'b01, 16'h1234, 2'b01, 3'd3, 3'd0, 1'b0);
    check("bypass_be01", 32'(rd_data[15:0]), 32'h0000AB34);

    // Both ports read an address being fully rewritten this cycle.
    wr(3'd5, 2'b11, 16'h00FF);
    step(1'b1, 1'b1, 3'd5, 2'b11, 16'hFF00, 2'b11, 3'd5, 3'd5, 1'b0);
    check("bypass_p0", 32'(rd_data[15:0]), 32'h0000FF00);
    check("bypass_p1", 32'(rd_data[31:16]), 32'h0000FF00);

    // wr_be=0 leaves the entry untouched.
    step(1'b1, 1'b1, 3'd5, 2'b00, 16'h1111, 2'b01, 3'd5, 3'd0, 1'b0);
    check("be_zero", 32'(rd_data[15:0]), 32'h0000FF00);

    // Random mixed traffic.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'b0);
    end
    idle();

    // Bulk clear; same-cycle write/read still accepted, then traffic dropped.
    fill(16'h5A5A);
    busy_cycles = 0;
    step(1'b1, 1'b1, 3'd2, 2'b11, 16'h1111, 2'b01, 3'd2, 3'd0, 1'b1);
    check("clr_cycle_read", 32'(rd_data[15:0]), 32'h00001111);
    for (int i = 0; i < 8; i++) random_busy_step();
    check("busy_len", busy_cycles, 8);
    read_all();

    // Reset on the third clear cycle, then a fresh full clear.
    fill(16'h5A5A);
    step(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b1);
    idle();
    idle();
    step(1'b0, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b0);
    check("rst_mid_clr_busy", 32'(busy), 32'h0);
    read_all();
    fill(16'hC3C3);
    busy_cycles = 0;
    step(1'b1, 1'b0, 3'd0, 2'b00, 16'h0, 2'b00, 3'd0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) idle();
    check("busy_len2", busy_cycles, 8);
    read_all();
    idle();

    // DEPTH=6 instance: out-of-range write dropped, out-of-range read errors.
    wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_be6 = 2'b11; wr_data6 = 16'hBEEF;
    idle();
    wr_addr6 = 3'd5; wr_data6 = 16'h1357;
    idle();
    wr_en6 = 1'b0; rd_en6 = 1'b1; rd_addr6 = 3'd7;
    idle();
    check("d6_valid_oor", 32'(rd_valid6), 32'h1);
    check("d6_data_oor", 32'(rd_data6), 32'h0);
    check("d6_err_oor", 32'(rd_err6), 32'h1);
    rd_addr6 = 3'd5;
    idle();
    check("d6_data_5", 32'(rd_data6), 32'h00001357);
    check("d6_err_5", 32'(rd_err6), 32'h0);
    rd_en6 = 1'b0;
    idle();
    check("d6_valid_idle", 32'(rd_valid6), 32'h0);
    check("d6_busy", 32'(busy6), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-read-port register bank: one byte-maskable write port and NUM_RD independent read ports, each with a registered 1-cycle read and write-to-read bypass. A sequenced bulk-clear engine zeroes the bank one entry per cycle, with a busy handshake. It replaces the single-port 8x16 register file in the datapath scratch-storage slot and serves operand fetch for multi-operand compute units.

## Interface
Parameters:
- DATA_WIDTH, 16, entry width in bits; multiple of 8, ≥8.
- DEPTH, 8, number of entries; ≥2, need not be a power of two.
- NUM_RD, 2, number of read ports; ≥1.
- Derived: ADDR_W = $clog2(DEPTH); BE_W = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  BE_W  byte enables; bit i covers data bits [8i+7:8i].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_WIDTH  read data, registered; port p at [p*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  out  NUM_RD  pulses 1 cycle after an accepted read.
- rd_err  out  NUM_RD  pulses with rd_valid when the address was ≥ DEPTH.
- clr_req  in  1  start bulk clear (single-cycle pulse or level).
- busy  out  1  clear in progress; reads and writes not accepted.

## Operation
- Reset (rst_n=0 at an edge): every entry = 0; rd_data = 0; rd_valid = 0; rd_err = 0; busy = 0; FSM = IDLE; clear pointer = 0. Reset overrides an in-progress clear.
- Write accepted when wr_en && !busy && wr_addr < DEPTH: bytes with wr_be[i]=1 updated, others kept. wr_be=0 is a no-op. Out-of-range writes are silently dropped.
- Read on port p accepted when rd_en[p] && !busy. Next cycle: rd_valid[p]=1; rd_data = entry contents, or 0 with rd_err[p]=1 if address ≥ DEPTH.
- Bypass: an accepted read and an accepted write to the same address in the same cycle return the merged new value (old bytes where wr_be=0, new bytes where 1). This holds per port. Several ports may read the same address.
- No accepted read on port p: rd_data[p] holds its last value; rd_valid[p]=0.
- FSM IDLE -> CLEAR when clr_req && state==IDLE. Same-cycle reads and writes are still accepted, because busy is still 0. The clear later overwrites that write.
- CLEAR: busy=1; entry[ptr] <= 0 each cycle, then ptr++. After zeroing entry DEPTH-1: ptr=0, state -> IDLE.
- clr_req while in CLEAR is ignored (no restart, no extension).
- rd_en/wr_en while busy are dropped; no rd_valid is produced.

## Timing
- Read latency: 1 cycle from accepting edge to rd_valid/rd_data.
- Write visible to a read issued the same cycle (bypass), or any later cycle.
- Clear: clr_req sampled at edge T. busy=1 in cycles T+1 … T+DEPTH. Entry k is zero after edge T+1+k. busy=0 from T+DEPTH+1. A read issued at cycle T+DEPTH+1 returns 0 for every entry.
- Throughput: one write and NUM_RD reads per cycle when not busy.

## Structure
- Package reg_bank_pkg: FSM state enum (IDLE, CLEAR) and the BE_W/ADDR_W derivation functions.
- Sub-module reg_bank_clear_fsm: owns the state, pointer and busy. It outputs clr_we and clr_addr to the storage array.
- Top level: storage array, write-merge logic, and one generate loop over NUM_RD for read registers and bypass.

## Test plan
- Reset, then read all 8 addresses on both ports -> rd_valid=1 next cycle, rd_data=0, rd_err=0.
- Write 0xABCD to addr 3 with wr_be=2'b11, then wr_be=2'b01 with 0x1234. Port0 reads addr 3 in the same cycle as the second write -> 0xAB34 next cycle.
- Port0 and port1 both read addr 5 holding 0x00FF while a 0xFF00 full write to addr 5 occurs in the same cycle -> both return 0xFF00.
- DEPTH=6: write addr 7 is dropped. Read addr 7 -> rd_data=0, rd_err=1. Read addr 5 is unaffected.
- Fill all entries with 0x5A5A, pulse clr_req at T -> busy high exactly 8 cycles (T+1..T+8). Reads and writes issued while busy give no rd_valid and no writes. Reads after that all return 0.
- Assert rst_n=0 at the 3rd CLEAR cycle -> next cycle busy=0, all entries 0. A new clr_req later runs a full DEPTH-cycle clear.
